// File: rtl/v_lane_pkg.sv
// Shared types and helpers for the vector lane sequencer: FSM states, LMUL field
// encoding and register-group / lane-group arithmetic.
package v_lane_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // lmul is log2 of registers per group; encodings above LmulMax never name a real LMUL
  localparam int unsigned LmulW = 3;
  localparam logic [LmulW-1:0] LmulMax = 3'd3;

  // log2 of active lane groups: min(lanes, log2(num_groups), lmul)
  function automatic int unsigned group_log2(input logic [LmulW-1:0] lmul,
                                             input logic [3:0] lanes,
                                             input int unsigned num_groups);
    int unsigned ng_log;
    int unsigned lg;
    ng_log = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((32'd1 << i) < num_groups) ng_log = i + 1;
    end
    lg = 32'(lanes);
    if (lg > ng_log) lg = ng_log;
    if (lg > 32'(lmul)) lg = 32'(lmul);
    return lg;
  endfunction

  function automatic int unsigned beat_count(input logic [LmulW-1:0] lmul,
                                             input logic [3:0] lanes,
                                             input int unsigned num_groups);
    return 32'd1 << (32'(lmul) - group_log2(lmul, lanes, num_groups));
  endfunction

endpackage

// File: rtl/v_lane_pipe.sv
// Lane latency tracker: a Depth-stage shift register of {valid, beat index} whose
// tail marks the cycle a beat's lane results are ready for capture.
module v_lane_pipe #(
  parameter int unsigned Depth = 1,
  parameter int unsigned IdxW  = 3
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  input  logic [IdxW-1:0] in_idx,
  output logic            out_valid,
  output logic [IdxW-1:0] out_idx
);

  logic [Depth-1:0] vld_q;
  logic [IdxW-1:0]  idx_q [Depth];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int unsigned i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[Depth-1];
  assign out_idx   = idx_q[Depth-1];

endmodule

// File: rtl/v_lane_sequencer.sv
// Vector lane sequencer: latches an LMUL register group, issues it to lane groups over beats
// and assembles returning ALU/MUL results. Define V_LANE_SEQ_PERF_EN for perf counters.
module v_lane_sequencer
  import v_lane_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned ELEN       = 32,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned MAX_LMUL   = 4,
  parameter int unsigned LANE_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic [3:0]                   op_instr_alu,
  input  logic                         is_mul,
  input  logic [LmulW-1:0]             lmul,
  input  logic [$clog2(NUM_GROUPS):0]  lanes,
  input  logic [MAX_LMUL*VLEN-1:0]     op_a,
  input  logic [MAX_LMUL*VLEN-1:0]     op_b,
  output logic [NUM_GROUPS*VLEN-1:0]   lane_op_a,
  output logic [NUM_GROUPS*VLEN-1:0]   lane_op_b,
  output logic [NUM_GROUPS-1:0]        lane_valid,
  input  logic [NUM_GROUPS*VLEN-1:0]   lane_res_alu,
  input  logic [NUM_GROUPS*VLEN-1:0]   lane_res_mul,
  output logic [MAX_LMUL*VLEN-1:0]     result_alu,
  output logic [MAX_LMUL*VLEN-1:0]     result_mul,
  output logic                         busy,
  output logic                         done,
`ifdef V_LANE_SEQ_PERF_EN
  output logic [31:0]                  perf_ops,
  output logic [31:0]                  perf_beats,
`endif
  output logic                         err
);

  localparam int unsigned LW = $clog2(NUM_GROUPS) + 1;
  localparam int unsigned BW = $clog2(MAX_LMUL) + 1;
  localparam logic [LmulW-1:0] MaxLmulLog  = LmulW'($clog2(MAX_LMUL));
  localparam logic [LW-1:0]    MaxLanesLog = LW'($clog2(NUM_GROUPS));

  if ((VLEN % ELEN) != 0) begin : gen_elen_check
    $error("VLEN must be a multiple of ELEN");
  end

  state_e                     state_q;
  logic [BW-1:0]              k_q, b_cnt_q;
  logic [2:0]                 log2g_q;
  logic [3:0]                 alu_op_q;
  logic                       mul_q;
  logic [MAX_LMUL*VLEN-1:0]   opa_q, opb_q;
  logic [VLEN-1:0]            res_alu_q [MAX_LMUL];
  logic [VLEN-1:0]            res_mul_q [MAX_LMUL];

  logic                       legal, noop, issue, cap_valid, last_cap;
  logic [BW-1:0]              cap_idx;
  int unsigned                g_cnt;
  logic [NUM_GROUPS-1:0]      grp_mask;
  logic [MAX_LMUL-1:0][NUM_GROUPS-1:0] iss_hit, cap_hit;

  assign legal    = (lmul <= MaxLmulLog) && (lmul <= LmulMax) && (lanes <= MaxLanesLog);
  assign noop     = (op_instr_alu == '0) && !is_mul;
  assign issue    = (state_q == StIssue);
  assign g_cnt    = 32'd1 << log2g_q;
  assign last_cap = cap_valid && (cap_idx == b_cnt_q - 1'b1);

  // Beat k routes register k*G+g to group g; the same map locates returning results.
  always_comb begin
    iss_hit  = '0;
    cap_hit  = '0;
    grp_mask = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      grp_mask[g] = (g < g_cnt);
      for (int unsigned r = 0; r < MAX_LMUL; r++) begin
        if (g < g_cnt) begin
          iss_hit[r][g] = (((32'(k_q) << log2g_q) + g) == r);
          cap_hit[r][g] = cap_valid && (((32'(cap_idx) << log2g_q) + g) == r);
        end
      end
    end
  end

  v_lane_pipe #(
    .Depth (LANE_LAT),
    .IdxW  (BW)
  ) u_pipe (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (issue),
    .in_idx    (k_q),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      b_cnt_q    <= '0;
      log2g_q    <= '0;
      alu_op_q   <= '0;
      mul_q      <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      lane_op_a  <= '0;
      lane_op_b  <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      lane_valid <= '0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (!legal) begin
              err <= 1'b1;
            end else begin
              opa_q    <= op_a;
              opb_q    <= op_b;
              alu_op_q <= op_instr_alu;
              mul_q    <= is_mul;
              log2g_q  <= 3'(group_log2(lmul, 4'(lanes), NUM_GROUPS));
              b_cnt_q  <= BW'(beat_count(lmul, 4'(lanes), NUM_GROUPS));
              k_q      <= '0;
              busy     <= 1'b1;
              state_q  <= noop ? StDone : StIssue;
            end
          end
        end
        StIssue: begin
          lane_valid <= grp_mask;
          for (int unsigned r = 0; r < MAX_LMUL; r++) begin
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
              if (iss_hit[r][g]) begin
                lane_op_a[g*VLEN +: VLEN] <= opa_q[r*VLEN +: VLEN];
                lane_op_b[g*VLEN +: VLEN] <= opb_q[r*VLEN +: VLEN];
              end
            end
          end
          k_q <= k_q + 1'b1;
          if (k_q == b_cnt_q - 1'b1) state_q <= StDrain;
        end
        StDrain: begin
          if (last_cap) state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned r = 0; r < MAX_LMUL; r++) begin
        res_alu_q[r] <= '0;
        res_mul_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < MAX_LMUL; r++) begin
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
          if (cap_hit[r][g]) begin
            if (alu_op_q != '0) res_alu_q[r] <= lane_res_alu[g*VLEN +: VLEN];
            if (mul_q) res_mul_q[r] <= lane_res_mul[g*VLEN +: VLEN];
          end
        end
      end
    end
  end

  for (genvar r = 0; r < MAX_LMUL; r++) begin : gen_result
    assign result_alu[r*VLEN +: VLEN] = res_alu_q[r];
    assign result_mul[r*VLEN +: VLEN] = res_mul_q[r];
  end

`ifdef V_LANE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_ops   <= '0;
      perf_beats <= '0;
    end else begin
      if (issue) perf_beats <= perf_beats + 32'd1;
      if ((state_q == StDone) && ((alu_op_q != '0) || mul_q)) perf_ops <= perf_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_v_lane_sequencer.sv
// Self-checking bench for v_lane_sequencer: a LANE_LAT=1 and a LANE_LAT=3 instance share
// stimulus; a scoreboard of expected results and latencies is checked on each done.
module tb_v_lane_sequencer;

  localparam int VLEN = 128;
  localparam int ELEN = 32;
  localparam int NG   = 4;
  localparam int ML   = 4;
  localparam int LW   = $clog2(NG) + 1;
  localparam int NLN  = VLEN / ELEN;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic              start;
  logic [3:0]        op_alu;
  logic              is_mul;
  logic [2:0]        lmul;
  logic [LW-1:0]     lanes;
  logic [ML*VLEN-1:0] op_a, op_b;

  logic [NG*VLEN-1:0] la1, lb1, ra1, rm1, la3, lb3, ra3, rm3;
  logic [NG-1:0]      lv1, lv3;
  logic [ML*VLEN-1:0] resa1, resm1, resa3, resm3;
  logic               busy1, done1, err1, busy3, done3, err3;
`ifdef V_LANE_SEQ_PERF_EN
  logic [31:0]        pops1, pbeats1, pops3, pbeats3;
`endif

  function automatic logic [VLEN-1:0] lane_add(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    for (int i = 0; i < NLN; i++) r[i*ELEN +: ELEN] = a[i*ELEN +: ELEN] + b[i*ELEN +: ELEN];
    return r;
  endfunction

  function automatic logic [VLEN-1:0] lane_mul(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    for (int i = 0; i < NLN; i++) r[i*ELEN +: ELEN] = a[i*ELEN +: ELEN] * b[i*ELEN +: ELEN];
    return r;
  endfunction

  function automatic logic [NG*VLEN-1:0] grp_add(input logic [NG*VLEN-1:0] a,
                                                 input logic [NG*VLEN-1:0] b);
    logic [NG*VLEN-1:0] r;
    for (int g = 0; g < NG; g++) r[g*VLEN +: VLEN] = lane_add(a[g*VLEN +: VLEN], b[g*VLEN +: VLEN]);
    return r;
  endfunction

  function automatic logic [NG*VLEN-1:0] grp_mul(input logic [NG*VLEN-1:0] a,
                                                 input logic [NG*VLEN-1:0] b);
    logic [NG*VLEN-1:0] r;
    for (int g = 0; g < NG; g++) r[g*VLEN +: VLEN] = lane_mul(a[g*VLEN +: VLEN], b[g*VLEN +: VLEN]);
    return r;
  endfunction

  // Lane array models: combinational for LANE_LAT=1, two register stages for LANE_LAT=3
  assign ra1 = grp_add(la1, lb1);
  assign rm1 = grp_mul(la1, lb1);
  logic [NG*VLEN-1:0] s1a, s2a, s1m, s2m;
  always @(posedge clk) begin
    s1a <= grp_add(la3, lb3);
    s2a <= s1a;
    s1m <= grp_mul(la3, lb3);
    s2m <= s1m;
  end
  assign ra3 = s2a;
  assign rm3 = s2m;

  v_lane_sequencer #(
    .VLEN(VLEN), .ELEN(ELEN), .NUM_GROUPS(NG), .MAX_LMUL(ML), .LANE_LAT(1)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .op_instr_alu(op_alu), .is_mul(is_mul),
    .lmul(lmul), .lanes(lanes), .op_a(op_a), .op_b(op_b),
    .lane_op_a(la1), .lane_op_b(lb1), .lane_valid(lv1),
    .lane_res_alu(ra1), .lane_res_mul(rm1), .result_alu(resa1), .result_mul(resm1),
    .busy(busy1), .done(done1),
`ifdef V_LANE_SEQ_PERF_EN
    .perf_ops(pops1), .perf_beats(pbeats1),
`endif
    .err(err1)
  );

  v_lane_sequencer #(
    .VLEN(VLEN), .ELEN(ELEN), .NUM_GROUPS(NG), .MAX_LMUL(ML), .LANE_LAT(3)
  ) dut3 (
    .clk(clk), .nrst(nrst), .start(start), .op_instr_alu(op_alu), .is_mul(is_mul),
    .lmul(lmul), .lanes(lanes), .op_a(op_a), .op_b(op_b),
    .lane_op_a(la3), .lane_op_b(lb3), .lane_valid(lv3),
    .lane_res_alu(ra3), .lane_res_mul(rm3), .result_alu(resa3), .result_mul(resm3),
    .busy(busy3), .done(done3),
`ifdef V_LANE_SEQ_PERF_EN
    .perf_ops(pops3), .perf_beats(pbeats3),
`endif
    .err(err3)
  );

  typedef struct {
    logic [ML*VLEN-1:0] alu;
    logic [ML*VLEN-1:0] mul;
    logic [NG-1:0]      mask;
    int                 lat;
  } exp_t;

  exp_t               sb_q[$];
  logic [ML*VLEN-1:0] mdl_alu, mdl_mul;
  int                 checks = 0;
  int                 fails = 0;

  function automatic logic s_done(input int i); return (i != 0) ? done3 : done1; endfunction
  function automatic logic s_busy(input int i); return (i != 0) ? busy3 : busy1; endfunction
  function automatic logic [NG-1:0] s_lv(input int i); return (i != 0) ? lv3 : lv1; endfunction
  function automatic logic [ML*VLEN-1:0] s_ra(input int i); return (i != 0) ? resa3 : resa1; endfunction
  function automatic logic [ML*VLEN-1:0] s_rm(input int i); return (i != 0) ? resm3 : resm1; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq();
    for (int r = 0; r < ML; r++) begin
      for (int l = 0; l < NLN; l++) begin
        op_a[r*VLEN + l*ELEN +: ELEN] = ELEN'(r + 1);
        op_b[r*VLEN + l*ELEN +: ELEN] = ELEN'(100 * (r + 1) + l);
      end
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ML; r++) begin
      for (int l = 0; l < NLN; l++) begin
        op_a[r*VLEN + l*ELEN +: ELEN] = $urandom;
        op_b[r*VLEN + l*ELEN +: ELEN] = $urandom;
      end
    end
  endtask

  // Push expectation, start the op (in the current cycle), wait for done, pop and compare.
  // poke>0 pulses an unrelated start in cycle poke, which a busy sequencer must ignore.
  task automatic run_op(input int inst, input logic [2:0] l, input logic [LW-1:0] ln,
                        input logic [3:0] alu, input logic m, input int poke, input string name);
    exp_t          e;
    int            r_cnt, g_cnt, n;
    bit            got;
    logic [NG-1:0] mask_seen;
    r_cnt = 1 << l;
    g_cnt = 1 << ln;
    if (g_cnt > NG) g_cnt = NG;
    if (g_cnt > r_cnt) g_cnt = r_cnt;
    e.alu = mdl_alu;
    e.mul = mdl_mul;
    for (int r = 0; r < r_cnt; r++) begin
      if (alu != 4'd0) e.alu[r*VLEN +: VLEN] = lane_add(op_a[r*VLEN +: VLEN], op_b[r*VLEN +: VLEN]);
      if (m) e.mul[r*VLEN +: VLEN] = lane_mul(op_a[r*VLEN +: VLEN], op_b[r*VLEN +: VLEN]);
    end
    if (alu == 4'd0 && !m) begin
      e.lat  = 1;
      e.mask = '0;
    end else begin
      e.lat  = r_cnt / g_cnt + ((inst != 0) ? 3 : 1) + 1;
      e.mask = NG'((1 << g_cnt) - 1);
    end
    mdl_alu = e.alu;
    mdl_mul = e.mul;
    sb_q.push_back(e);

    lmul = l; lanes = ln; op_alu = alu; is_mul = m; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = ~op_a;
    op_b = ~op_b;
    checks++;
    if (s_busy(inst) !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, s_busy(inst));
    end
    n = 0; got = 0; mask_seen = '0;
    while (!got && n < 64) begin
      tick();
      n++;
      if (n == 1) mask_seen = s_lv(inst);
      if (n == poke) begin
        start = 1'b1; lmul = 3'd0; lanes = '0; op_alu = 4'd0; is_mul = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (s_done(inst) === 1'b1) got = 1;
    end
    e = sb_q.pop_front();
    checks++;
    if (!got || n != e.lat) begin
      fails++;
      $display("FAIL %s done_latency: got %0d cycles (seen=%0b) expected %0d", name, n, got, e.lat);
    end
    checks++;
    if (mask_seen !== e.mask) begin
      fails++;
      $display("FAIL %s first_lane_valid: got %b expected %b", name, mask_seen, e.mask);
    end
    checks++;
    if (s_busy(inst) !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, s_busy(inst));
    end
    checks++;
    if (s_ra(inst) !== e.alu) begin
      fails++;
      $display("FAIL %s result_alu: got %h expected %h", name, s_ra(inst), e.alu);
    end
    checks++;
    if (s_rm(inst) !== e.mul) begin
      fails++;
      $display("FAIL %s result_mul: got %h expected %h", name, s_rm(inst), e.mul);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; op_alu = '0; is_mul = 1'b0; lmul = '0; lanes = '0; op_a = '0; op_b = '0;
    nrst = 1'b0;
    mdl_alu = '0; mdl_mul = '0;
    repeat (2) tick();
    checks++;
    if ({busy1, done1, err1, lv1} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b done=%b err=%b lv=%b expected all 0",
               busy1, done1, err1, lv1);
    end
    checks++;
    if ({la1, lb1} !== '0) begin
      fails++;
      $display("FAIL reset_lane_op: got %h expected 0", la1);
    end
    nrst = 1'b1;
    tick();
    checks++;
    if ({resa1, resm1} !== '0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_results: got alu=%h busy=%b expected 0", resa1, busy1);
    end
  endtask

  task automatic test_multi_beat();
    fill_seq();
    run_op(0, 3'd2, LW'(0), 4'd1, 1'b1, 0, "multi_beat");
  endtask

  task automatic test_wide();
    fill_seq();
    run_op(0, 3'd2, LW'(2), 4'd1, 1'b1, 0, "wide_one_beat");
  endtask

  task automatic test_partial();
    fill_rand();
    run_op(0, 3'd0, LW'(2), 4'd3, 1'b1, 0, "single_reg");
  endtask

  task automatic test_illegal_noop();
    fill_rand();
    lmul = 3'd3; lanes = '0; op_alu = 4'd1; is_mul = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err1 !== 1'b1 || busy1 !== 1'b0 || lv1 !== '0) begin
      fails++;
      $display("FAIL illegal_lmul: got err=%b busy=%b lv=%b expected err=1 busy=0 lv=0",
               err1, busy1, lv1);
    end
    tick();
    checks++;
    if (err1 !== 1'b0 || busy1 !== 1'b0 || lv1 !== '0) begin
      fails++;
      $display("FAIL illegal_pulse_width: got err=%b busy=%b lv=%b expected 0 0 0", err1, busy1, lv1);
    end
    lmul = 3'd0; lanes = LW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL illegal_lanes: got err=%b busy=%b expected err=1 busy=0", err1, busy1);
    end
    tick();
    run_op(0, 3'd2, LW'(0), 4'd0, 1'b0, 0, "noop");
    tick();
    checks++;
    if (done1 !== 1'b0) begin
      fails++;
      $display("FAIL noop_done_width: got %b expected 0", done1);
    end
  endtask

  task automatic test_reset_midop();
    fill_rand();
    lmul = 3'd2; lanes = '0; op_alu = 4'd1; is_mul = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    nrst = 1'b0;
    #1;
    checks++;
    if ({lv1, busy1, done1, err1} !== '0 || {la1, lb1} !== '0 || {resa1, resm1} !== '0) begin
      fails++;
      $display("FAIL reset_midop: got lv=%b busy=%b done=%b err=%b expected all 0",
               lv1, busy1, done1, err1);
    end
    #2;
    nrst = 1'b1;
    mdl_alu = '0; mdl_mul = '0;
    tick();
    fill_rand();
    run_op(0, 3'd2, LW'(1), 4'd2, 1'b1, 2, "after_reset_busy_start");
  endtask

  task automatic test_back_to_back();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    mdl_alu = '0; mdl_mul = '0;
    tick();
    fill_seq();
    run_op(1, 3'd2, LW'(0), 4'd1, 1'b1, 0, "b2b_op1");
    fill_rand();
    run_op(1, 3'd2, LW'(0), 4'd1, 1'b1, 0, "b2b_op2");
`ifdef V_LANE_SEQ_PERF_EN
    checks++;
    if (pops3 !== 32'd2 || pbeats3 !== 32'd8) begin
      fails++;
      $display("FAIL perf_counters: got ops=%0d beats=%0d expected ops=2 beats=8", pops3, pbeats3);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_multi_beat();
    test_wide();
    test_partial();
    test_illegal_noop();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/v_lane_sequencer.md
# v_lane_sequencer

Parametrised vector lane sequencer that replaces the fixed 4/8/16-lane ALU/MUL dispatch. It latches an LMUL register group of operands on a `start` handshake and issues VLEN-wide register slices to up to NUM_GROUPS lane groups over one or more beats. It tracks a fixed lane pipeline latency and writes returning ALU and MUL results into per-register result buffers, ending each operation with a one-cycle `done` pulse. It sits between the vector register file read port and the lane array (v_alu/v_mul instances live outside this block).

## Interface
- VLEN, 128, bits per vector register (one lane group = VLEN/ELEN lanes)
- ELEN, 32, bits per lane
- NUM_GROUPS, 4, physical lane groups (power of two, 1..8)
- MAX_LMUL, 4, max registers per group (power of two, 1..8)
- LANE_LAT, 1, cycles from lane issue to lane result (1..4)
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when `busy`=0
- op_instr_alu  in  4  ALU opcode, 0 = no ALU op
- is_mul  in  1  multiply op
- lmul  in  3  log2 registers per group (0..log2 MAX_LMUL)
- lanes  in  clog2(NUM_GROUPS)+1  log2 active lane groups
- op_a, op_b  in  MAX_LMUL*VLEN  operand register groups, register r at [r*VLEN +: VLEN]
- lane_op_a, lane_op_b  out  NUM_GROUPS*VLEN  per-group operand slices
- lane_valid  out  NUM_GROUPS  per-group issue strobe
- lane_res_alu, lane_res_mul  in  NUM_GROUPS*VLEN  lane results, LANE_LAT after issue
- result_alu, result_mul  out  MAX_LMUL*VLEN  assembled results
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: illegal config rejected

## Operation
- Derived quantities: R = 1<<lmul registers, G = min(1<<lanes, NUM_GROUPS, R) active groups, B = R/G beats.
- Illegal config: lmul > log2(MAX_LMUL) or (1<<lanes) > NUM_GROUPS. `start` then pulses `err` next cycle. No state change, `busy` stays 0.
- No-op: `start` with op_instr_alu=0 and is_mul=0 is accepted, then pulses `done` next cycle with results unchanged.
- FSM states:
  - IDLE: on legal `start` → ISSUE; latch operands, opcode, R, G, B.
  - ISSUE: beat counter k = 0..B-1, one beat per cycle. Group g gets register k*G+g, and lane_valid[g]=1 for g<G. After beat B-1 → DRAIN.
  - DRAIN: wait for the last result → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Capture: LANE_LAT cycles after beat k, lane_res_*[g] is written to result_*[(k*G+g)] for g<G. Register entries not covered keep their previous value.
- Idle outputs: lane_valid=0, lane_op_* hold their last values.
- `start` while busy=1: ignored, no error.
- Inputs op_a/op_b may change after acceptance without effect.

## Timing
- Reset (async, any state): FSM→IDLE, counters 0, lane_valid=0, lane_op_*=0, result_*=0, busy=0, done=0, err=0. Any in-flight beats are discarded.
- Start accepted at edge E0. busy=1 from E0 until the edge that asserts done, and 0 while done=1. Beat k is issued in cycle E0+1+k.
- Capture of beat k happens at edge E0+1+k+LANE_LAT. done is high in the cycle after the final capture, so total latency = B+LANE_LAT+1 cycles.
- A new `start` can be accepted in the same cycle done=1 (busy=0).
- Results are stable from done until the next accepted start plus LANE_LAT+1.

## Configuration
- V_LANE_SEQ_PERF_EN defined:
  - Adds outputs perf_ops (32 b, completed non-no-op operations) and perf_beats (32 b, issued beats).
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: the ports do not exist and there is no counter logic.

## Structure
- Package v_lane_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE)
  - LMUL encoding constants
  - function beat_count(lmul, lanes, NUM_GROUPS)
- Sub-module v_lane_pipe is a LANE_LAT-deep shift register carrying {valid, beat index}. It drives result capture and DRAIN exit.

## Test plan
- NUM_GROUPS=4, lmul=2, lanes=0, op_a reg r = r+1 per lane, lane model = a+b, LANE_LAT=1 → 4 beats; result_alu reg r = sums; done at E0+6.
- Same config, lanes=2 → 1 beat, lane_valid=4'b1111, done at E0+3, identical results.
- lmul=0, lanes=2 → G=1, lane_valid=4'b0001, only result reg 0 written; regs 1..3 keep their old values.
- lmul=3 with MAX_LMUL=4 → err pulse, busy=0, no lane_valid; is_mul=0, op=0 → done next cycle.
- Reset asserted during beat 2 of 4 → all outputs 0 immediately. A subsequent start completes normally. start during busy is ignored.
- LANE_LAT=3, back-to-back starts on done cycle: results of op 2 are not corrupted by op 1. With V_LANE_SEQ_PERF_EN, perf_ops=2 and perf_beats=8.
